// File: rtl/ft600_wb_echo_master.sv
// Wishbone echo master: polls FT600 status, pops RX words into a local FIFO and writes them back to TX.
// Two cycles per transaction with a combinational ack; stalls on wb_ack_i and aborts after ACK_TIMEOUT cycles.
module ft600_wb_echo_master #(
   parameter int ADDR_W      = 2,
   parameter int FIFO_DEPTH  = 16,
   parameter int POLL_GAP    = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          err_clr,
   output logic                          wb_cyc_o,
   output logic                          wb_stb_o,
   output logic                          wb_we_o,
   output logic [ADDR_W-1:0]             wb_addr_o,
   output logic [31:0]                   wb_dat_o,
   input  logic [31:0]                   wb_dat_i,
   input  logic                          wb_ack_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   rx_count,
   output logic [31:0]                   tx_count,
   output logic                          busy,
   output logic                          err_timeout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
   localparam logic [LW-1:0]     FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [TW-1:0]     TO_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [GW-1:0]     GAP_LAST = GW'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);
   localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_POP    = ADDR_W'(2);

   typedef enum logic [2:0] {IDLE, STAT, POP, PUSH, GAP} state_t;

   state_t        state;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [15:0]   rx_word_q;
   logic [TW-1:0] tmr;
   logic [GW-1:0] gap_cnt;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop_done;
   logic          unused_stat;

   assign fifo_empty  = (fifo_level == '0);
   assign fifo_full   = (fifo_level == FULL_LVL);
   assign pop_done    = (state == POP) && wb_cyc_o && wb_ack_i;
   assign busy        = wb_cyc_o || !fifo_empty;
   assign unused_stat = ^wb_dat_i[31:18];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_addr_o   <= '0;
         wb_dat_o    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         rx_count    <= '0;
         tx_count    <= '0;
         err_timeout <= 1'b0;
         rx_word_q   <= '0;
         tmr         <= '0;
         gap_cnt     <= '0;
      end else begin
         if (err_clr) err_timeout <= 1'b0;
         case (state)
            IDLE: if (enable) state <= STAT;
            STAT, POP, PUSH: begin
               if (!wb_cyc_o) begin
                  wb_cyc_o  <= 1'b1;
                  wb_stb_o  <= 1'b1;
                  tmr       <= '0;
                  wb_we_o   <= (state != STAT);
                  wb_addr_o <= (state == STAT) ? A_STAT : (state == POP) ? A_POP : A_TX;
                  wb_dat_o  <= (state == PUSH) ? {16'h0, mem[rd_ptr]} : 32'h0;
               end else if (wb_ack_i) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
                  wb_addr_o <= '0;
                  wb_dat_o  <= '0;
                  state     <= enable ? STAT : IDLE;
                  if (state == STAT) begin
                     // The RX word is captured here; the later POP write only frees the slave entry.
                     rx_word_q <= wb_dat_i[15:0];
                     if (!enable) begin
                        state <= IDLE;
                     end else if (!fifo_empty && !wb_dat_i[17]) begin
                        state <= PUSH;
                     end else if (wb_dat_i[16] && !fifo_full) begin
                        state <= POP;
                     end else begin
                        state   <= GAP;
                        gap_cnt <= '0;
                     end
                  end else if (state == POP) begin
                     wr_ptr     <= wr_ptr + AW'(1);
                     fifo_level <= fifo_level + LW'(1);
                     rx_count   <= rx_count + 32'd1;
                  end else begin
                     rd_ptr     <= rd_ptr + AW'(1);
                     fifo_level <= fifo_level - LW'(1);
                     tx_count   <= tx_count + 32'd1;
                  end
               end else if (tmr == TO_LAST) begin
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  wb_we_o     <= 1'b0;
                  wb_addr_o   <= '0;
                  wb_dat_o    <= '0;
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) state <= enable ? STAT : IDLE;
               else gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pop_done) mem[wr_ptr] <= rx_word_q;
   end
endmodule

// File: tb/tb_ft600_wb_echo_master.sv
// Bench for ft600_wb_echo_master: behavioural FT600 slave plus a queue-based echo model.
module tb_ft600_wb_echo_master;
   localparam int POLL_GAP = 8;
   localparam logic [2:0] OP_STAT = 3'b000, OP_PUSH = 3'b101, OP_POP = 3'b110;

   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, err_clr = 1'b0;
   logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, busy, err_timeout;
   logic [1:0]  wb_addr_o;
   logic [31:0] wb_dat_o, wb_dat_i, rx_count, tx_count;
   logic [4:0]  fifo_level;

   always #5 clk = ~clk;

   ft600_wb_echo_master dut (
      .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .fifo_level(fifo_level), .rx_count(rx_count), .tx_count(tx_count),
      .busy(busy), .err_timeout(err_timeout)
   );

   // ack_mode: 0 combinational, 1 after ack_lat cycles, 2 never, 3 reads only
   int          ack_mode = 0, ack_lat = 0, hold = 0;
   logic        spur = 1'b0, tx_full = 1'b0, rx_avail = 1'b0;
   logic [15:0] rx_head = '0, exp_w;
   logic [15:0] rxq[$], mfifo[$], txq_obs[$], sent[$];
   logic [2:0]  trace[$];
   int unsigned stat_t[$];
   int unsigned cyc_n = 0;
   int          m_rx = 0, m_tx = 0, n_tests = 0, n_fail = 0, viol = 0;
   logic        prev_done = 1'b0, prev_cyc = 1'b0;
   logic [34:0] prev_bus = '0;

   assign wb_dat_i = {14'h0, tx_full, rx_avail, rx_head};
   assign wb_ack_i = spur || (wb_cyc_o && wb_stb_o &&
                     (ack_mode == 0 || (ack_mode == 1 && hold >= ack_lat) || (ack_mode == 3 && !wb_we_o)));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Slave side effects and scoreboard, evaluated on completed bus cycles
   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      hold  <= wb_cyc_o ? hold + 1 : 0;
      if (!rst && wb_cyc_o && wb_ack_i) begin
         trace.push_back({wb_we_o, wb_addr_o});
         if (!wb_we_o) begin
            stat_t.push_back(cyc_n);
         end else if (wb_addr_o == 2'd2) begin
            check("pop_dat", wb_dat_o, 32'h0);
            check("pop_rx_avail", 32'(rxq.size() != 0), 32'h1);
            if (rxq.size() != 0) mfifo.push_back(rxq.pop_front());
            m_rx++;
         end else if (wb_addr_o == 2'd1) begin
            exp_w = 16'hDEAD;
            if (mfifo.size() != 0) exp_w = mfifo.pop_front();
            check("push_dat", wb_dat_o, {16'h0, exp_w});
            txq_obs.push_back(wb_dat_o[15:0]);
            m_tx++;
         end
      end
   end

   // Protocol watch: cyc==stb, one idle cycle after completion, request held stable until ack
   always @(negedge clk) begin
      if (!rst) begin
         if (wb_cyc_o !== wb_stb_o) viol++;
         if (prev_done && wb_cyc_o) viol++;
         if (wb_cyc_o && prev_cyc && !prev_done && {wb_we_o, wb_addr_o, wb_dat_o} !== prev_bus) viol++;
      end
      prev_done = wb_cyc_o && wb_ack_i;
      prev_cyc  = wb_cyc_o;
      prev_bus  = {wb_we_o, wb_addr_o, wb_dat_o};
      rx_avail  = (rxq.size() != 0);
      rx_head   = rx_avail ? rxq[0] : 16'h0;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, trk, t0, npush, inj;
      bit seen_pop;
      logic [15:0] w;

      // Reset, disabled
      tick(5);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (wb_cyc_o) n++;
         @(negedge clk);
      end
      check("rst_no_cyc", 32'(n), 0);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_rx", rx_count, 0);
      check("rst_tx", tx_count, 0);
      check("rst_err", 32'(err_timeout), 0);
      check("rst_busy", 32'(busy), 0);

      // Single word echo
      rxq.push_back(16'hABCD);
      tick(1);
      enable = 1'b1;
      for (int i = 0; i < 50 && trace.size() < 2; i++) @(negedge clk);
      check("t2_level_after_pop", 32'(fifo_level), 1);
      for (int i = 0; i < 100 && m_tx < 1; i++) @(negedge clk);
      check("t2_op0", 32'(trace[0]), 32'(OP_STAT));
      check("t2_op1", 32'(trace[1]), 32'(OP_POP));
      check("t2_op2", 32'(trace[2]), 32'(OP_STAT));
      check("t2_op3", 32'(trace[3]), 32'(OP_PUSH));
      check("t2_txword", 32'(txq_obs[0]), 32'h0000ABCD);
      check("t2_rx", rx_count, 1);
      check("t2_tx", tx_count, 1);
      enable = 1'b0;
      tick(30);

      // Fill to full while TX is blocked, then drain
      trace.delete(); txq_obs.delete(); stat_t.delete();
      for (int i = 0; i < 20; i++) rxq.push_back(16'(i));
      tx_full = 1'b1;
      tick(2);
      t0 = m_rx;
      enable = 1'b1;
      for (int i = 0; i < 600 && fifo_level != 5'd16; i++) @(negedge clk);
      check("t3_full", 32'(fifo_level), 16);
      trk = trace.size();
      tick(100);
      n = 0;
      for (int i = trk; i < trace.size(); i++) if (trace[i] != OP_STAT) n++;
      check("t3_only_polls", 32'(n), 0);
      check("t3_rx", rx_count, 32'(t0 + 16));
      n = stat_t.size();
      check("t3_poll_period", stat_t[n-1] - stat_t[n-2], 32'(POLL_GAP + 2));
      t0 = m_tx;
      trk = trace.size();
      tx_full = 1'b0;
      for (int i = 0; i < 1500 && !(m_tx == t0 + 20 && fifo_level == 0); i++) @(negedge clk);
      npush = 0; seen_pop = 1'b0;
      for (int i = trk; i < trace.size(); i++) begin
         if (trace[i] == OP_POP) seen_pop = 1'b1;
         if (!seen_pop && trace[i] == OP_PUSH) npush++;
      end
      check("t3_push_burst", 32'(npush), 16);
      for (int i = 0; i < 20; i++) check("t3_order", 32'(txq_obs[i]), 32'(i));
      check("t3_tx", tx_count, 32'(t0 + 20));
      enable = 1'b0;
      tick(30);

      // Status read never acked
      ack_mode = 2;
      t0 = m_rx;
      enable = 1'b1;
      for (int i = 0; i < 20 && !wb_cyc_o; i++) @(negedge clk);
      n = 0;
      while (wb_cyc_o && n < 400) begin
         n++;
         if (n == 100) enable = 1'b0;
         @(negedge clk);
      end
      check("t4_timeout_len", 32'(n), 255);
      check("t4_err", 32'(err_timeout), 1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (wb_cyc_o) n++;
         @(negedge clk);
      end
      check("t4_idle", 32'(n), 0);
      check("t4_rx_kept", rx_count, 32'(t0));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t4_err_clr", 32'(err_timeout), 0);

      // POP never acked, err_clr coincident with the timeout edge
      rxq.push_back(16'h1234);
      ack_mode = 3;
      tick(1);
      enable = 1'b1;
      for (int i = 0; i < 40 && !(wb_cyc_o && wb_we_o); i++) @(negedge clk);
      tick(254);
      check("t4b_still_high", 32'(wb_cyc_o), 1);
      err_clr = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check("t4b_set_wins", 32'(err_timeout), 1);
      check("t4b_cyc_drop", 32'(wb_cyc_o), 0);
      check("t4b_level", 32'(fifo_level), 0);
      check("t4b_rx", rx_count, 32'(t0));
      rxq.delete();
      tick(3);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t4b_err_clr", 32'(err_timeout), 0);

      // Late ack with enable dropped mid-PUSH, then resume
      ack_mode = 0;
      sent.delete();
      for (int i = 0; i < 4; i++) begin
         w = 16'($urandom);
         rxq.push_back(w);
         sent.push_back(w);
      end
      tx_full = 1'b1;
      tick(1);
      enable = 1'b1;
      for (int i = 0; i < 200 && fifo_level != 5'd4; i++) @(negedge clk);
      check("t5_loaded", 32'(fifo_level), 4);
      txq_obs.delete();
      ack_mode = 1; ack_lat = 3; tx_full = 1'b0;
      for (int i = 0; i < 100 && !(wb_cyc_o && wb_we_o && wb_addr_o == 2'd1); i++) @(negedge clk);
      enable = 1'b0;
      trk = trace.size();
      t0 = m_tx;
      tick(40);
      check("t5_push_done", tx_count, 32'(t0 + 1));
      check("t5_kept", 32'(fifo_level), 3);
      check("t5_one_xfer", 32'(trace.size() - trk), 1);
      check("t5_idle_busy", 32'(busy), 1);
      spur = 1'b1;
      tick(3);
      spur = 1'b0;
      tick(2);
      check("t5_spur_level", 32'(fifo_level), 3);
      check("t5_spur_tx", tx_count, 32'(t0 + 1));
      check("t5_spur_trace", 32'(trace.size() - trk), 1);
      ack_mode = 0;
      enable = 1'b1;
      for (int i = 0; i < 300 && !(fifo_level == 0 && m_tx == t0 + 4 && !wb_cyc_o); i++) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) check("t5_order", 32'(txq_obs[i]), 32'(sent[i]));
      tick(30);

      // Reset while a POP waits for ack
      for (int i = 0; i < 3; i++) rxq.push_back(16'($urandom));
      tx_full = 1'b1;
      tick(1);
      enable = 1'b1;
      for (int i = 0; i < 100 && fifo_level != 5'd2; i++) @(negedge clk);
      ack_mode = 3;
      for (int i = 0; i < 50 && !(wb_cyc_o && wb_we_o); i++) @(negedge clk);
      check("t6_pop_pending", 32'(wb_cyc_o && wb_we_o), 1);
      rst = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("t6_cyc", 32'(wb_cyc_o), 0);
      check("t6_level", 32'(fifo_level), 0);
      check("t6_rx", rx_count, 0);
      tick(2);
      rst = 1'b0;
      rxq.delete(); mfifo.delete(); txq_obs.delete(); trace.delete();
      m_rx = 0; m_tx = 0;
      tx_full = 1'b0;

      // Randomized soak: random words, TX backpressure and ack latency
      ack_mode = 1;
      sent.delete();
      inj = 0;
      tick(2);
      enable = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         if (inj < 40 && $urandom_range(0, 2) == 0) begin
            w = 16'($urandom);
            rxq.push_back(w);
            sent.push_back(w);
            inj++;
         end
         tx_full = (inj < 40) && ($urandom_range(0, 3) == 0);
         if (!wb_cyc_o) ack_lat = $urandom_range(0, 3);
         @(negedge clk);
         if (inj == 40 && rxq.size() == 0 && mfifo.size() == 0 && !wb_cyc_o) break;
      end
      enable = 1'b0;
      tick(30);
      check("t7_rx", rx_count, 40);
      check("t7_tx", tx_count, 40);
      check("t7_level", 32'(fifo_level), 0);
      for (int i = 0; i < 40; i++) check("t7_order", 32'(txq_obs[i]), 32'(sent[i]));

      check("protocol", 32'(viol), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
